// File: rtl/sar_search_ctrl.sv
// sar_search_ctrl
//
// Successive-approximation search controller. Drives the probe side of a
// magnitude comparator and binary-searches, MSB first, for the largest
// WIDTH-bit value that is not greater than the comparator's hidden target.
// The outcome is reported with a one-cycle done pulse.
//
// Build option: SAR_EARLY_EXIT_EN
//    defined   - an exact-match verdict ends the search immediately
//    undefined - every search issues exactly WIDTH probes (fixed latency)
//
// Ports:
//    clk          rising-edge clock
//    rst          synchronous reset, active-high
//    start        begin a search (sampled only in IDLE)
//    probe        candidate value presented to the comparator
//    probe_valid  probe is stable and awaits a verdict
//    cmp_valid    verdict valid; transfer on probe_valid & cmp_valid
//    cmp_lt       probe <  target
//    cmp_eq       probe == target
//    cmp_gt       probe >  target
//    busy         search in progress (PROBE state)
//    done         one-cycle pulse at the end of a search
//    result       search outcome, held until overwritten by the next search
//    found        exact match seen in the last search
//    err          last search aborted on an illegal verdict
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start
// PROBE  | probe presented, waiting for a verdict transfer
// FINISH | one-cycle wrap-up: latch result, pulse done

module sar_search_ctrl #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic [WIDTH-1:0] probe,
   output logic             probe_valid,
   input  logic             cmp_valid,
   input  logic             cmp_lt,
   input  logic             cmp_eq,
   input  logic             cmp_gt,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             found,
   output logic             err
);

   localparam int KW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [KW-1:0]    K_TOP = KW'(WIDTH - 1);
   localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_PROBE,
      S_FINISH
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [KW-1:0]    k_q, k_d;
   logic [WIDTH-1:0] probe_q, probe_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             found_q, found_d;
   logic             err_q, err_d;

   logic             legal;
   logic             early_hit;

   // Exactly one verdict flag must be high for a transfer to be usable.
   assign legal = ({cmp_lt, cmp_eq, cmp_gt} == 3'b100) ||
                  ({cmp_lt, cmp_eq, cmp_gt} == 3'b010) ||
                  ({cmp_lt, cmp_eq, cmp_gt} == 3'b001);

`ifdef SAR_EARLY_EXIT_EN
   assign early_hit = cmp_eq;
`else
   assign early_hit = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      k_d      = k_q;
      probe_d  = probe_q;
      result_d = result_q;
      found_d  = found_q;
      err_d    = err_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               acc_d   = '0;
               k_d     = K_TOP;
               found_d = 1'b0;
               err_d   = 1'b0;
               probe_d = ONE << K_TOP;
               state_d = S_PROBE;
            end
         end

         S_PROBE: begin
            if (cmp_valid) begin
               if (!legal) begin
                  err_d   = 1'b1;
                  state_d = S_FINISH;
               end else begin
                  // Keep the trial bit when probe <= target.
                  if (cmp_lt || cmp_eq) begin
                     acc_d = probe_q;
                  end
                  if (cmp_eq) begin
                     found_d = 1'b1;
                  end
                  if ((k_q == '0) || early_hit) begin
                     state_d = S_FINISH;
                  end else begin
                     k_d     = k_q - 1'b1;
                     probe_d = acc_d | (ONE << k_d);
                  end
               end
            end
         end

         S_FINISH: begin
            result_d = acc_q;
            state_d  = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         acc_q    <= '0;
         k_q      <= K_TOP;
         probe_q  <= '0;
         result_q <= '0;
         found_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         k_q      <= k_d;
         probe_q  <= probe_d;
         result_q <= result_d;
         found_q  <= found_d;
         err_q    <= err_d;
      end
   end

   assign probe       = probe_q;
   assign probe_valid = (state_q == S_PROBE);
   assign busy        = (state_q == S_PROBE);
   assign done        = (state_q == S_FINISH);
   assign result      = result_q;
   assign found       = found_q;
   assign err         = err_q;

endmodule

// File: tb/tb_sar_search_ctrl.sv
module tb_sar_search_ctrl;

   localparam int WIDTH = 4;

   logic             clk;
   logic             rst;
   logic             start;
   logic [WIDTH-1:0] probe;
   logic             probe_valid;
   logic             cmp_valid;
   logic             cmp_lt;
   logic             cmp_eq;
   logic             cmp_gt;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             found;
   logic             err;

   // Environment comparator with an override that forces an illegal verdict.
   logic [WIDTH-1:0] tgt;
   logic             force_ill;

   assign cmp_lt = force_ill ? 1'b1 : (probe < tgt);
   assign cmp_eq = force_ill ? 1'b0 : (probe == tgt);
   assign cmp_gt = force_ill ? 1'b1 : (probe > tgt);

   sar_search_ctrl #(.WIDTH(WIDTH)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .probe       (probe),
      .probe_valid (probe_valid),
      .cmp_valid   (cmp_valid),
      .cmp_lt      (cmp_lt),
      .cmp_eq      (cmp_eq),
      .cmp_gt      (cmp_gt),
      .busy        (busy),
      .done        (done),
      .result      (result),
      .found       (found),
      .err         (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   int probe_log [16];
   int nprobe;
   int done_cyc;

   task automatic chk(input string tag, input int obs, input int exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Log every transferred probe until done, starting at cycle c0.
   task automatic track(input int c0);
      int c;
      nprobe   = 0;
      done_cyc = -1;
      c        = c0;
      while (c < c0 + 40) begin
         if (probe_valid && cmp_valid && nprobe < 16) begin
            probe_log[nprobe] = int'(probe);
            nprobe++;
         end
         if (done) begin
            done_cyc = c;
            break;
         end
         @(posedge clk); #1;
         c++;
      end
      if (done_cyc < 0) chk("done_timeout", 0, 1);
   endtask

   task automatic do_search(input int t);
      tgt   = WIDTH'(t);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      track(1);
   endtask

   task automatic chk_probes(input string tag, input int n, input int p0,
                             input int p1, input int p2, input int p3);
      int exp_p [4];
      exp_p = '{p0, p1, p2, p3};
      chk({tag, "_nprobe"}, nprobe, n);
      for (int i = 0; i < n; i++) begin
         chk($sformatf("%s_probe%0d", tag, i), probe_log[i], exp_p[i]);
      end
   endtask

   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      cmp_valid = 1'b1;
      tgt       = '0;
      force_ill = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_probe", int'(probe), 0);
      chk("rst_probe_valid", int'(probe_valid), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_result", int'(result), 0);
      chk("rst_found", int'(found), 0);
      chk("rst_err", int'(err), 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Target 11: 8 lt, 12 gt, 10 lt, 11 eq.
      do_search(11);
      chk_probes("t11", 4, 8, 12, 10, 11);
      chk("t11_done_cyc", done_cyc, 5);
      chk("t11_busy_at_done", int'(busy), 0);
      @(posedge clk); #1;
      chk("t11_result", int'(result), 11);
      chk("t11_found", int'(found), 1);
      chk("t11_err", int'(err), 0);
      chk("t11_done_pulse", int'(done), 0);

      // Target 12: exact match on the second probe.
      do_search(12);
`ifdef SAR_EARLY_EXIT_EN
      chk_probes("t12", 2, 8, 12, 0, 0);
      chk("t12_done_cyc", done_cyc, 3);
`else
      chk_probes("t12", 4, 8, 12, 14, 13);
      chk("t12_done_cyc", done_cyc, 5);
`endif
      @(posedge clk); #1;
      chk("t12_result", int'(result), 12);
      chk("t12_found", int'(found), 1);

      // Target 0: every probe is gt.
      do_search(0);
      chk_probes("t0", 4, 8, 4, 2, 1);
      @(posedge clk); #1;
      chk("t0_result", int'(result), 0);
      chk("t0_found", int'(found), 0);

      // Target 15: final probe is all-ones.
      do_search(15);
      chk_probes("t15", 4, 8, 12, 14, 15);
      @(posedge clk); #1;
      chk("t15_result", int'(result), 15);
      chk("t15_found", int'(found), 1);

      // Stall 3 cycles on the second probe.
      tgt   = 4'd11;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("stall_p0", int'(probe), 8);
      @(posedge clk); #1;
      cmp_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk($sformatf("stall_hold_probe%0d", i), int'(probe), 12);
         chk($sformatf("stall_hold_valid%0d", i), int'(probe_valid), 1);
      end
      cmp_valid = 1'b1;
      track(5);
      chk_probes("stall", 3, 12, 10, 11, 0);
      @(posedge clk); #1;
      chk("stall_result", int'(result), 11);
      chk("stall_found", int'(found), 1);

      // Illegal verdict (lt & gt) on the second probe; start pulses ignored.
      tgt   = 4'd11;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      chk("ill_p1", int'(probe), 12);
      force_ill = 1'b1;
      start     = 1'b1;
      @(posedge clk); #1;
      force_ill = 1'b0;
      chk("ill_done", int'(done), 1);
      chk("ill_err", int'(err), 1);
      chk("ill_busy", int'(busy), 0);
      @(posedge clk); #1;
      start = 1'b0;
      chk("ill_result", int'(result), 8);
      chk("ill_found", int'(found), 0);
      chk("ill_err_held", int'(err), 1);
      chk("ill_start_ignored", int'(busy), 0);
      chk("ill_done_pulse", int'(done), 0);

      // Reset during the third probe.
      tgt   = 4'd11;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("rmid_p2", int'(probe), 10);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("rmid_probe", int'(probe), 0);
      chk("rmid_valid", int'(probe_valid), 0);
      chk("rmid_busy", int'(busy), 0);
      chk("rmid_done", int'(done), 0);
      chk("rmid_result", int'(result), 0);
      chk("rmid_found", int'(found), 0);
      chk("rmid_err", int'(err), 0);
      @(posedge clk); #1;
      chk("rmid_no_done", int'(done), 0);
      chk("rmid_idle", int'(busy), 0);
      do_search(11);
      chk_probes("rclean", 4, 8, 12, 10, 11);
      @(posedge clk); #1;
      chk("rclean_result", int'(result), 11);
      chk("rclean_found", int'(found), 1);
      chk("rclean_err", int'(err), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
